// File: rtl/ex_mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package ex_mdu_pkg;

  localparam int unsigned Wordnum = 32;

  // funct3 encodings for the M extension
  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StCorr = 2'd2,
    StDone = 2'd3
  } mdu_state_e;

  // rs1 is treated as signed for every op except MULHU, DIVU and REMU
  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  // rs2 is signed only for MUL, MULH, DIV and REM
  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OpMul) || (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/ex_mdu_step.sv
// One combinational iteration shared by the shift-add multiplier and restoring divider.
// Multiply: acc = {partial_hi, multiplier}. Divide: acc = {remainder, quotient}.
module ex_mdu_step
  import ex_mdu_pkg::*;
(
  input  logic                 i_is_div,
  input  logic [2*Wordnum-1:0] i_acc,
  input  logic [Wordnum-1:0]   i_opnd,
  output logic [2*Wordnum-1:0] o_acc,
  output logic                 o_qbit
);

  logic [Wordnum:0]   w_sum;
  logic               w_ge;
  logic [Wordnum-1:0] w_rem;

  // Select between an add-and-shift-right and a shift-left-and-trial-subtract step
  always_comb begin
    w_sum  = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_opnd} : 33'd0);
    // The shifted remainder is 33 bits wide, so compare with the bit that falls off the top
    w_ge   = {1'b0, i_acc[63:31]} >= {2'b00, i_opnd};
    // True difference is below the divisor, so 32 bits is enough when w_ge holds
    w_rem  = i_acc[62:31] - i_opnd;
    o_qbit = 1'b0;
    if (i_is_div) begin
      o_qbit = w_ge;
      // Quotient LSB is left 0 here; the caller merges o_qbit in
      o_acc  = w_ge ? {w_rem, i_acc[30:0], 1'b0} : {i_acc[62:0], 1'b0};
    end else begin
      o_acc  = {w_sum, i_acc[31:1]};
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// 32 iterations in CALC, sign fix-up in CORR, one-cycle done pulse in DONE.
module ex_mdu
  import ex_mdu_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_kill,
  input  logic [2:0]          i_mdu_op,
  input  logic [Wordnum-1:0]  i_rs1_data,
  input  logic [Wordnum-1:0]  i_rs2_data,
  output logic [Wordnum-1:0]  o_result,
  output logic                o_done,
  output logic                o_busy,
  output logic                o_hold_req
);

  mdu_state_e           r_state;
  logic [4:0]           r_cnt;
  logic [2*Wordnum-1:0] r_acc;
  logic [Wordnum-1:0]   r_opnd;
  logic [Wordnum-1:0]   r_result;
  logic [2:0]           r_op;
  logic                 r_neg;
  logic                 r_done;

  logic                 w_s1;
  logic                 w_s2;
  logic [Wordnum-1:0]   w_mag1;
  logic [Wordnum-1:0]   w_mag2;
  logic                 w_is_div;
  logic                 w_neg;
  logic                 w_div0;
  logic                 w_ovf;
  logic [Wordnum-1:0]   w_special;
  logic [2*Wordnum-1:0] w_step_acc;
  logic                 w_qbit;
  logic [2*Wordnum-1:0] w_prod;
  logic [Wordnum-1:0]   w_quot;
  logic [Wordnum-1:0]   w_rem;
  logic [Wordnum-1:0]   w_corr;

  // Operand magnitudes, result sign and special-case detection at issue
  always_comb begin
    w_is_div  = i_mdu_op[2];
    w_s1      = rs1_signed(i_mdu_op) & i_rs1_data[31];
    w_s2      = rs2_signed(i_mdu_op) & i_rs2_data[31];
    w_mag1    = w_s1 ? (32'd0 - i_rs1_data) : i_rs1_data;
    w_mag2    = w_s2 ? (32'd0 - i_rs2_data) : i_rs2_data;
    // Remainder follows the dividend; product and quotient follow the XOR of signs
    w_neg     = (w_is_div & i_mdu_op[1]) ? w_s1 : (w_s1 ^ w_s2);
    w_div0    = w_is_div & (i_rs2_data == 32'd0);
    w_ovf     = w_is_div & ~i_mdu_op[0] & (i_rs1_data == 32'h8000_0000) &
                (i_rs2_data == 32'hFFFF_FFFF);
    if (w_div0) begin
      w_special = i_mdu_op[1] ? i_rs1_data : 32'hFFFF_FFFF;
    end else begin
      w_special = i_mdu_op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  ex_mdu_step u_step (
    .i_is_div (r_op[2]),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step_acc),
    .o_qbit   (w_qbit)
  );

  // Sign correction and result selection for the CORR state
  always_comb begin
    w_prod = r_neg ? (64'd0 - r_acc) : r_acc;
    w_quot = r_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    w_rem  = r_neg ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    case (r_op)
      OpMul:                     w_corr = w_prod[31:0];
      OpMulh, OpMulhsu, OpMulhu: w_corr = w_prod[63:32];
      OpDiv, OpDivu:             w_corr = w_quot;
      default:                   w_corr = w_rem;
    endcase
  end

  // Control FSM with datapath registers and registered done/result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= 5'd0;
      r_acc    <= 64'd0;
      r_opnd   <= 32'd0;
      r_result <= 32'd0;
      r_op     <= 3'd0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_kill) begin
      // Abort without a done pulse; r_result keeps its previous value
      r_state <= StIdle;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_op <= i_mdu_op;
            if (w_div0 | w_ovf) begin
              r_result <= w_special;
              r_done   <= 1'b1;
              r_state  <= StDone;
            end else begin
              // Divide keeps the dividend in the quotient half; multiply keeps the multiplier low
              r_acc   <= {32'd0, w_is_div ? w_mag1 : w_mag2};
              r_opnd  <= w_is_div ? w_mag2 : w_mag1;
              r_neg   <= w_neg;
              r_cnt   <= 5'd0;
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          r_acc <= w_step_acc | {63'd0, w_qbit};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= StCorr;
          end
        end
        StCorr: begin
          r_result <= w_corr;
          r_done   <= 1'b1;
          r_state  <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Stall covers the issue cycle itself; it drops in DONE so EX consumes the result
  assign o_hold_req = ((r_state == StIdle) & i_start & ~i_kill) |
                      (r_state == StCalc) | (r_state == StCorr);
  assign o_busy     = (r_state != StIdle);
  assign o_done     = r_done;
  assign o_result   = r_result;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_mdu;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        hold;

  int          n_tests;
  int          n_fail;
  logic [31:0] last_res;

  ex_mdu dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_kill     (kill),
    .i_mdu_op   (op),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .o_result   (result),
    .o_done     (done),
    .o_busy     (busy),
    .o_hold_req (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f)
      3'b000: begin t = sa * sb; return t[31:0]; end
      3'b001: begin t = sa * sb; return t[63:32]; end
      3'b010: begin t = sa * ub; return t[63:32]; end
      3'b011: begin t = {32'd0, a} * {32'd0, b}; return t[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        t = sa / sb;
        return t[31:0];
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        t = sa % sb;
        return t[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op, scramble inputs after issue, optionally re-pulse start mid-CALC
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit extra_start, input string tag);
    logic [31:0] exp;
    int          lat;
    int          cyc;
    int          hold_cnt;
    bit          seen;
    exp = ref_model(f, a, b);
    lat = exp_latency(f, a, b);
    @(negedge clk);
    op = f; rs1 = a; rs2 = b; start = 1'b1;
    #1;
    hold_cnt = hold ? 1 : 0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
      cyc++;
      if (extra_start && cyc == 5) start = 1'b1;
      #1;
      if (done) begin
        seen = 1'b1;
        check({tag, " result"}, result, exp);
        check({tag, " latency"}, cyc, lat);
        check({tag, " hold cycles"}, hold_cnt, lat);
        check({tag, " hold in done"}, {31'd0, hold}, 32'd0);
      end else if (hold) begin
        hold_cnt++;
      end
    end
    start = 1'b0;
    if (!seen) check({tag, " timeout"}, 32'd0, 32'd1);
    last_res = exp;
  endtask

  initial begin
    bit          any_done;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    n_tests = 0;
    n_fail = 0;
    last_res = 32'd0;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (2) @(negedge clk);
    check("reset result", result, 32'd0);
    check("reset flags", {29'd0, done, busy, hold}, 32'd0);
    rst = 1'b0;

    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, "MUL 7*-3");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MULHU");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MULHSU");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0, "MULH min*min");
    run_op(3'b100, 32'hFFFF_FFEC, 32'd3, 1'b0, "DIV -20/3");
    run_op(3'b110, 32'hFFFF_FFEC, 32'd3, 1'b0, "REM -20/3");
    run_op(3'b101, 32'd100, 32'd0, 1'b0, "DIVU by 0");
    run_op(3'b111, 32'd100, 32'd0, 1'b0, "REMU by 0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "DIV ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "REM ovf");
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, "DIVU max/1");
    run_op(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "MUL restart ignored");

    // Randomized ops with occasional forced corner operands
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op(f, a, b, (i % 5) == 0, "rand");
    end

    // Kill and start in the same idle cycle: nothing issues
    @(negedge clk);
    op = 3'b000; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1; kill = 1'b1;
    #1;
    check("kill+start hold", {31'd0, hold}, 32'd0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    #1;
    check("kill+start busy", {31'd0, busy}, 32'd0);

    // Kill in cycle 10 of a DIVU
    @(negedge clk);
    op = 3'b101; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("kill busy", {31'd0, busy}, 32'd0);
    check("kill done", {31'd0, done}, 32'd0);
    check("kill result held", result, last_res);
    run_op(3'b101, 32'd1000, 32'd7, 1'b0, "DIVU after kill");

    // Kill for a while with no issue: done must stay low
    any_done = 1'b0;
    @(negedge clk);
    op = 3'b100; rs1 = 32'd77; rs2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      kill = 1'b0;
      #1;
      if (done) any_done = 1'b1;
    end
    check("no done after kill", {31'd0, any_done}, 32'd0);

    // Restart pulse in CALC, then asynchronous reset mid-CALC
    @(negedge clk);
    op = 3'b000; rs1 = 32'd3; rs2 = 32'd9; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (c == 6) check("busy after 2nd start", {31'd0, busy}, 32'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    check("async rst result", result, 32'd0);
    check("async rst flags", {29'd0, done, busy, hold}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'b110, 32'hFFFF_FF9C, 32'h0000_0007, 1'b0, "REM after rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
